// File: rtl/alp_pkg.sv
// Shared encodings for the ALP carry/flag controller: carry-source select, operand width,
// two-word sequencing state.
package alp_pkg;

    localparam logic [1:0] CIN_ZERO = 2'd0;
    localparam logic [1:0] CIN_ONE  = 2'd1;
    localparam logic [1:0] CIN_ALUC = 2'd2;
    localparam logic [1:0] CIN_PSLC = 2'd3;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_WORD = 2'd1;
    localparam logic [1:0] W_LONG = 2'd2;

    typedef enum logic {IDLE, MP_HI} mp_state_t;

    // Index of the most significant slice taking part in an operation of the given width.
    function automatic int unsigned top_slice(logic [1:0] width, int unsigned nslice);
        case (width)
            W_BYTE:  return 1;
            W_WORD:  return 3;
            default: return nslice - 1;
        endcase
    endfunction

endpackage

// File: rtl/alp_carry_ctl_if.sv
// Slice-array side bundle for alp_carry_ctl. ALP_DIGIT_CARRY_EN adds per-slice registered carries.
interface alp_carry_ctl_if #(
    parameter int unsigned NSLICE = 8
);
    logic [NSLICE-1:0]   g_in_h;
    logic [NSLICE-1:0]   p_in_h;
    logic [NSLICE-1:0]   v_in_h;
    logic [4*NSLICE-1:0] aluq_h;
    logic [1:0]          cin_sel_h;
    logic [1:0]          width_h;
    logic                sub_h;
    logic                cc_en_h;
    logic                mp_start_h;
    logic                stall_h;
    logic [NSLICE-1:0]   carry_in_h;
    logic                alu_c_h;
    logic                cc_n_h;
    logic                cc_z_h;
    logic                cc_v_h;
    logic                cc_c_h;
    logic                mp_hi_h;
`ifdef ALP_DIGIT_CARRY_EN
    logic [NSLICE-1:0]   digit_c_h;

    modport master (
        output g_in_h, p_in_h, v_in_h, aluq_h, cin_sel_h, width_h, sub_h, cc_en_h,
               mp_start_h, stall_h,
        input  carry_in_h, alu_c_h, cc_n_h, cc_z_h, cc_v_h, cc_c_h, mp_hi_h, digit_c_h
    );
    modport slave (
        input  g_in_h, p_in_h, v_in_h, aluq_h, cin_sel_h, width_h, sub_h, cc_en_h,
               mp_start_h, stall_h,
        output carry_in_h, alu_c_h, cc_n_h, cc_z_h, cc_v_h, cc_c_h, mp_hi_h, digit_c_h
    );
`else
    modport master (
        output g_in_h, p_in_h, v_in_h, aluq_h, cin_sel_h, width_h, sub_h, cc_en_h,
               mp_start_h, stall_h,
        input  carry_in_h, alu_c_h, cc_n_h, cc_z_h, cc_v_h, cc_c_h, mp_hi_h
    );
    modport slave (
        input  g_in_h, p_in_h, v_in_h, aluq_h, cin_sel_h, width_h, sub_h, cc_en_h,
               mp_start_h, stall_h,
        output carry_in_h, alu_c_h, cc_n_h, cc_z_h, cc_v_h, cc_c_h, mp_hi_h
    );
`endif

endinterface

// File: rtl/alp_cla.sv
// Single-level carry lookahead across the slice array; c[i] is the carry into slice i,
// c[NSLICE] the carry out of the top slice.
module alp_cla #(
    parameter int unsigned NSLICE = 8
) (
    input  logic [NSLICE-1:0] g,
    input  logic [NSLICE-1:0] p,
    input  logic              c0,
    output logic [NSLICE:0]   c
);

    always_comb begin
        c[0] = c0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

endmodule

// File: rtl/alp_carry_ctl.sv
// ALP carry/flag controller: slice carry chain, registered ALU carry, NZVC and two-word sequencing.
// Optional ALP_DIGIT_CARRY_EN registers every slice carry-out for decimal adjust.
module alp_carry_ctl
    import alp_pkg::*;
#(
    parameter int unsigned NSLICE = 8
) (
    input logic            clk_h,
    input logic            reset_l,
    alp_carry_ctl_if.slave bus
);

    mp_state_t       state_q;
    logic            alu_c_q;
    logic            n_q;
    logic            z_q;
    logic            v_q;
    logic            c_q;
    logic            c0;
    logic [NSLICE:0] c;
    int unsigned     top;
    logic            cout;
    logic            sign;
    logic            zero;
    logic            ovf;

    // The high word of a two-word op always continues from the low word's carry.
    always_comb begin
        if (state_q == MP_HI) begin
            c0 = alu_c_q;
        end else begin
            case (bus.cin_sel_h)
                CIN_ZERO: c0 = 1'b0;
                CIN_ONE:  c0 = 1'b1;
                CIN_ALUC: c0 = alu_c_q;
                default:  c0 = c_q;
            endcase
        end
    end

    alp_cla #(
        .NSLICE(NSLICE)
    ) u_cla (
        .g  (bus.g_in_h),
        .p  (bus.p_in_h),
        .c0 (c0),
        .c  (c)
    );

    assign bus.carry_in_h = c[NSLICE-1:0];

    always_comb begin
        top  = top_slice(bus.width_h, NSLICE);
        cout = 1'b0;
        sign = 1'b0;
        ovf  = 1'b0;
        zero = 1'b1;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (i == top) begin
                cout = c[i+1];
                sign = bus.aluq_h[4*i+3];
                ovf  = bus.v_in_h[i];
            end
        end
        for (int unsigned j = 0; j < 4 * NSLICE; j++) begin
            if (j <= 4 * top + 3 && bus.aluq_h[j]) zero = 1'b0;
        end
    end

`ifdef ALP_DIGIT_CARRY_EN
    logic [NSLICE-1:0] digit_q;
    assign bus.digit_c_h = digit_q;
`endif

    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            alu_c_q <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
`ifdef ALP_DIGIT_CARRY_EN
            digit_q <= '0;
`endif
        end else if (bus.cc_en_h && !bus.stall_h) begin
            alu_c_q <= cout;
            n_q     <= sign;
            v_q     <= ovf;
            c_q     <= cout ^ bus.sub_h;
            // High word only reports zero if the low word was zero as well.
            z_q     <= (state_q == MP_HI) ? (zero & z_q) : zero;
            state_q <= (state_q == IDLE && bus.mp_start_h) ? MP_HI : IDLE;
`ifdef ALP_DIGIT_CARRY_EN
            digit_q <= c[NSLICE:1];
`endif
        end
    end

    assign bus.alu_c_h = alu_c_q;
    assign bus.cc_n_h  = n_q;
    assign bus.cc_z_h  = z_q;
    assign bus.cc_v_h  = v_q;
    assign bus.cc_c_h  = c_q;
    assign bus.mp_hi_h = (state_q == MP_HI);

endmodule

// File: tb/tb_alp_carry_ctl.sv
// Directed bench for alp_carry_ctl: arithmetic reference model checked every cycle plus
// hand-computed literal expectations.
module tb_alp_carry_ctl;

    localparam int NS = 8;

    typedef struct packed {
        logic [NS:0] c;
        logic        cout;
        logic        sign;
        logic        zero;
        logic        ovf;
    } eval_t;

    logic clk_h;
    logic reset_l;
    int   n_cmp;
    int   n_bad;
    bit   cmp_on;

    alp_carry_ctl_if #(.NSLICE(NS)) bus ();

    alp_carry_ctl #(
        .NSLICE(NS)
    ) dut (
        .clk_h   (clk_h),
        .reset_l (reset_l),
        .bus     (bus)
    );

    initial clk_h = 1'b0;
    always #5 clk_h = ~clk_h;

    // Carry into position i: some lower slice generates and everything between propagates,
    // or the chain input survives all propagates below i.
    function automatic logic [NS:0] lookahead(logic [NS-1:0] g, logic [NS-1:0] p, logic c0);
        logic [NS:0] r;
        logic        ci;
        logic        term;
        for (int i = 0; i <= NS; i++) begin
            ci = c0;
            for (int j = 0; j < i; j++) if (!p[j]) ci = 1'b0;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) if (!p[k]) term = 1'b0;
                ci = ci | term;
            end
            r[i] = ci;
        end
        return r;
    endfunction

    function automatic eval_t model_eval(logic [NS-1:0] g, logic [NS-1:0] p, logic [NS-1:0] v,
                                         logic [4*NS-1:0] q, logic [1:0] w, logic c0);
        eval_t       e;
        int          nbits;
        logic [63:0] aq;
        logic [63:0] mask;
        nbits  = (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 4 * NS;
        aq     = 64'(q);
        mask   = (64'd1 << nbits) - 64'd1;
        e.c    = lookahead(g, p, c0);
        e.cout = e.c[nbits/4];
        e.sign = aq[nbits-1];
        e.zero = ((aq & mask) == 64'd0);
        e.ovf  = v[nbits/4-1];
        return e;
    endfunction

    logic          m_alu_c, m_n, m_z, m_v, m_c, m_hi;
    logic [NS-1:0] m_digit;
    logic          m_c0;
    eval_t         m_e;

    always_comb begin
        m_c0 = 1'b0;
        if (m_hi) m_c0 = m_alu_c;
        else begin
            case (bus.cin_sel_h)
                2'd0: m_c0 = 1'b0;
                2'd1: m_c0 = 1'b1;
                2'd2: m_c0 = m_alu_c;
                default: m_c0 = m_c;
            endcase
        end
        m_e = model_eval(bus.g_in_h, bus.p_in_h, bus.v_in_h, bus.aluq_h, bus.width_h, m_c0);
    end

    always @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            m_alu_c <= 1'b0; m_n <= 1'b0; m_z <= 1'b0; m_v <= 1'b0; m_c <= 1'b0;
            m_hi <= 1'b0; m_digit <= '0;
        end else if (bus.cc_en_h && !bus.stall_h) begin
            m_alu_c <= m_e.cout;
            m_n     <= m_e.sign;
            m_v     <= m_e.ovf;
            m_c     <= m_e.cout ^ bus.sub_h;
            m_z     <= m_hi ? (m_e.zero & m_z) : m_e.zero;
            m_hi    <= !m_hi && bus.mp_start_h;
            m_digit <= m_e.c[NS:1];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs are sampled mid-cycle, well clear of both clock edges and input changes.
    always @(negedge clk_h) begin
        #3;
        if (cmp_on) begin
            chk("carry_in", 64'(bus.carry_in_h), 64'(m_e.c[NS-1:0]));
            chk("alu_c", 64'(bus.alu_c_h), 64'(m_alu_c));
            chk("cc_n", 64'(bus.cc_n_h), 64'(m_n));
            chk("cc_z", 64'(bus.cc_z_h), 64'(m_z));
            chk("cc_v", 64'(bus.cc_v_h), 64'(m_v));
            chk("cc_c", 64'(bus.cc_c_h), 64'(m_c));
            chk("mp_hi", 64'(bus.mp_hi_h), 64'(m_hi));
`ifdef ALP_DIGIT_CARRY_EN
            chk("digit_c", 64'(bus.digit_c_h), 64'(m_digit));
`endif
        end
    end

    task automatic tick();
        @(negedge clk_h);
        #1;
    endtask

    task automatic drive(input logic [7:0] g, input logic [7:0] p, input logic [7:0] v,
                         input logic [31:0] q, input logic [1:0] cs, input logic [1:0] w,
                         input logic sub, input logic en, input logic mps, input logic st);
        bus.g_in_h = g; bus.p_in_h = p; bus.v_in_h = v; bus.aluq_h = q;
        bus.cin_sel_h = cs; bus.width_h = w; bus.sub_h = sub; bus.cc_en_h = en;
        bus.mp_start_h = mps; bus.stall_h = st;
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] nzvc, input logic ac,
                             input logic hi);
        chk({tag, "_nzvc"}, 64'({bus.cc_n_h, bus.cc_z_h, bus.cc_v_h, bus.cc_c_h}), 64'(nzvc));
        chk({tag, "_alu_c"}, 64'(bus.alu_c_h), 64'(ac));
        chk({tag, "_mp_hi"}, 64'(bus.mp_hi_h), 64'(hi));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cmp_on = 1'b0;
        reset_l = 1'b0;
        drive(8'h00, 8'hFF, 8'h00, 32'h0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp_on = 1'b1;
        tick(); tick();
        chk_flags("reset", 4'b0000, 1'b0, 1'b0);
        #1 chk("reset_carry_in", 64'(bus.carry_in_h), 64'h0FF);

        // Long add, carry generated only by the top slice.
        tick();
        reset_l = 1'b1;
        drive(8'h80, 8'h7F, 8'h00, 32'h0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("long_carry_in", 64'(bus.carry_in_h), 64'h00);
        tick();
        chk_flags("long", 4'b0101, 1'b1, 1'b0);
        chk("model_pin_c", 64'(m_c), 64'h1);

        // Full ripple from cin_sel=1, then same chain with cin_sel=0 and flags held.
        drive(8'h00, 8'hFF, 8'h00, 32'h8000_0000, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 chk("ripple_carry_in", 64'(bus.carry_in_h), 64'hFF);
        tick();
        chk_flags("ripple", 4'b1001, 1'b1, 1'b0);
        drive(8'h00, 8'hFF, 8'h00, 32'h8000_0000, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("ripple0_carry_in", 64'(bus.carry_in_h), 64'h00);
        tick();
        chk_flags("hold", 4'b1001, 1'b1, 1'b0);

        // Byte subtract: top slice 1, borrow reported in C.
        drive(8'h00, 8'h00, 8'h02, 32'h1234_5680, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_flags("byte", 4'b1011, 1'b0, 1'b0);
        chk("model_pin_n", 64'(m_n), 64'h1);

        // cin_sel=3 picks up cc_c (1), cin_sel=2 picks up alu_c (0).
        drive(8'h00, 8'hFF, 8'h00, 32'h0, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("pslc_carry_in", 64'(bus.carry_in_h), 64'hFF);
        bus.cin_sel_h = 2'd2;
        #1 chk("aluc_carry_in", 64'(bus.carry_in_h), 64'h00);

        // Word op: top slice 3.
        drive(8'h08, 8'h00, 8'h08, 32'h0001_0000, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_flags("word", 4'b0111, 1'b1, 1'b0);

        // Quadword low word, then stalled high word (mp_start also raised), then release.
        drive(8'h80, 8'h00, 8'h00, 32'h0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_flags("qlow", 4'b0101, 1'b1, 1'b1);
        drive(8'h00, 8'h00, 8'h00, 32'h1, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        #1 chk("qhi_carry_in", 64'(bus.carry_in_h), 64'h01);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_flags("stall", 4'b0101, 1'b1, 1'b1);
        end
        drive(8'h00, 8'h00, 8'h00, 32'h1, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_flags("qhigh", 4'b0000, 1'b0, 1'b0);

        // MP_HI holds without cc_en; mp_start in MP_HI does not restart.
        drive(8'h80, 8'h00, 8'h00, 32'h0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_flags("q2low", 4'b0101, 1'b1, 1'b1);
        drive(8'h00, 8'h00, 8'h00, 32'h1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_flags("q2wait", 4'b0101, 1'b1, 1'b1);
        drive(8'h00, 8'h00, 8'h00, 32'h0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_flags("q2high", 4'b0100, 1'b0, 1'b0);

        // Asynchronous reset in the middle of MP_HI.
        drive(8'h80, 8'h00, 8'h00, 32'h8000_0000, 2'd0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_flags("q3low", 4'b1001, 1'b1, 1'b1);
        drive(8'h80, 8'h00, 8'h00, 32'h8000_0000, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_l = 1'b0;
        #1 chk_flags("async_rst", 4'b0000, 1'b0, 1'b0);
        tick();
        reset_l = 1'b1;
        drive(8'h00, 8'h01, 8'h00, 32'h0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("post_rst_carry_in", 64'(bus.carry_in_h), 64'h03);
        tick();
        tick();
        cmp_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
